// File: rtl/uart_rx_cfg_bd.sv
// rtl/uart_rx_cfg_bd.sv - UART receiver, runtime baud divisor; UART_RX_FRM_CHK_EN adds the stop-bit frm_err flag
module uart_rx_cfg_bd (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    input  logic [15:0] baud,
    input  logic        clr_rdy,
    output logic [7:0]  rx_data,
    output logic        rdy
`ifdef UART_RX_FRM_CHK_EN
    ,
    output logic        frm_err
`endif
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t      state_q;
    logic        rx_meta_q;
    logic        rx_s_q;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic        done_q;
    logic [7:0]  rx_data_q;
    logic        rdy_q;
`ifdef UART_RX_FRM_CHK_EN
    logic        stop_bad_q;
    logic        frm_q;
`endif

    logic [15:0] cnt_d;
    logic [15:0] half_baud;

    // cnt_q trails the cycles elapsed since start detect by one, so the
    // start-bit test looks at the incremented value
    assign cnt_d     = cnt_q + 16'd1;
    assign half_baud = {1'b0, baud[15:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_meta_q  <= 1'b1;
            rx_s_q     <= 1'b1;
            cnt_q      <= 16'd0;
            bit_q      <= 3'd0;
            shift_q    <= 8'h00;
            done_q     <= 1'b0;
            rx_data_q  <= 8'h00;
            rdy_q      <= 1'b0;
`ifdef UART_RX_FRM_CHK_EN
            stop_bad_q <= 1'b0;
            frm_q      <= 1'b0;
`endif
        end else begin
            rx_meta_q <= RX;
            rx_s_q    <= rx_meta_q;

            if (clr_rdy) begin
                rdy_q <= 1'b0;
`ifdef UART_RX_FRM_CHK_EN
                frm_q <= 1'b0;
`endif
            end

            // Byte hand-off one clock after the stop sample; overrides clr_rdy
            if (done_q) begin
                done_q    <= 1'b0;
                rx_data_q <= shift_q;
                rdy_q     <= 1'b1;
`ifdef UART_RX_FRM_CHK_EN
                frm_q     <= stop_bad_q;
`endif
            end

            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_q <= START;
                        cnt_q   <= 16'd0;
                        bit_q   <= 3'd0;
                        rdy_q   <= 1'b0;
`ifdef UART_RX_FRM_CHK_EN
                        frm_q   <= 1'b0;
`endif
                    end
                end
                START: begin
                    if (cnt_d == half_baud) begin
                        cnt_q   <= 16'd0;
                        state_q <= rx_s_q ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DATA: begin
                    if (cnt_q == baud) begin
                        cnt_q   <= 16'd0;
                        shift_q <= {rx_s_q, shift_q[7:1]};
                        bit_q   <= bit_q + 3'd1;
                        if (bit_q == 3'd7) begin
                            state_q <= STOP;
                        end
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                STOP: begin
                    // Leaving here mid stop bit lets a back-to-back start be caught
                    if (cnt_q == baud) begin
                        cnt_q   <= 16'd0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
`ifdef UART_RX_FRM_CHK_EN
                        stop_bad_q <= ~rx_s_q;
`endif
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data = rx_data_q;
    assign rdy     = rdy_q;
`ifdef UART_RX_FRM_CHK_EN
    assign frm_err = frm_q;
`endif

endmodule

// File: tb/tb_uart_rx_cfg_bd.sv
// tb/tb_uart_rx_cfg_bd.sv - randomized self-checking bench for uart_rx_cfg_bd
module tb_uart_rx_cfg_bd;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RX;
    logic [15:0] baud;
    logic        clr_rdy;
    logic [7:0]  rx_data;
    logic        rdy;
`ifdef UART_RX_FRM_CHK_EN
    logic        frm_err;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_e0  = 0;

    logic       rdy_prev = 1'b0;
    logic [7:0] got_data[$];
    int         got_cyc[$];
    logic [7:0] exp_data[$];
    int         exp_cyc_q[$];

    uart_rx_cfg_bd dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .RX      (RX),
        .baud    (baud),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
`ifdef UART_RX_FRM_CHK_EN
        ,
        .frm_err (frm_err)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Record every rising edge of rdy with the byte and the clock it appeared on
    always @(negedge clk) begin
        if (rdy && !rdy_prev) begin
            got_data.push_back(rx_data);
            got_cyc.push_back(cyc);
        end
        rdy_prev <= rdy;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line-start edge E0 is the edge just before RX falls; two synchronizer
    // flops put start detect at E0+3, and rdy shows one clock after the stop sample
    function automatic int exp_rdy_cyc(input int e0, input int b);
        return e0 + 3 + (b >> 1) + 9 * (b + 1) + 1;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic stop);
        logic [9:0] f;
        f = {stop, d, 1'b0};
        last_e0 = cyc;
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            if (i == 9 && !stop) begin
                // Bad stop bit held only past the sample point, then released
                repeat ((int'(baud) >> 1) + 1) tick();
                RX = 1'b1;
                repeat (int'(baud) - (int'(baud) >> 1)) tick();
            end else begin
                repeat (int'(baud) + 1) tick();
            end
        end
        RX = 1'b1;
    endtask

    task automatic ack();
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
    endtask

    task automatic wait_rdy(input string tag, input int limit);
        for (int i = 0; i < limit && !rdy; i++) tick();
        check(tag, rdy, 1);
    endtask

    initial begin
        int e0;
        int b;
        int nexp;
        logic [7:0] held;
        logic [7:0] d;

        rst_n = 1'b0; RX = 1'b1; baud = 16'd33; clr_rdy = 1'b0;
        repeat (3) tick();
        check("reset_rdy", rdy, 0);
        check("reset_data", rx_data, 8'h00);
`ifdef UART_RX_FRM_CHK_EN
        check("reset_frm", frm_err, 0);
`endif
        rst_n = 1'b1;
        repeat (5) tick();

        // Single byte with exact rdy timing
        got_data.delete(); got_cyc.delete();
        send_frame(8'hA5, 1'b1);
        e0 = last_e0;
        repeat (10) tick();
        check("a5_count", got_data.size(), 1);
        if (got_data.size() > 0) begin
            check("a5_data", got_data[0], 8'hA5);
            check("a5_time", got_cyc[0], exp_rdy_cyc(e0, 33));
        end
        check("a5_rdy_held", rdy, 1);
`ifdef UART_RX_FRM_CHK_EN
        check("a5_frm", frm_err, 0);
`endif
        ack();
        check("a5_ack", rdy, 0);

        // Back-to-back frames, no idle gap, acked as they arrive
        got_data.delete(); got_cyc.delete();
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
            end
            begin
                for (int k = 0; k < 2; k++) begin
                    wait_rdy("b2b_wait", 800);
                    ack();
                end
            end
        join
        repeat (10) tick();
        check("b2b_count", got_data.size(), 2);
        if (got_data.size() == 2) begin
            check("b2b_first", got_data[0], 8'h00);
            check("b2b_second", got_data[1], 8'hFF);
        end
        check("b2b_acked", rdy, 0);

        // False start: 5-clock glitch
        got_data.delete(); got_cyc.delete();
        held = rx_data;
        RX = 1'b0;
        repeat (5) tick();
        RX = 1'b1;
        repeat (60) tick();
        check("false_rdy", rdy, 0);
        check("false_data", rx_data, held);
        check("false_count", got_data.size(), 0);

        // Random bytes and divisors, unacknowledged bytes get overwritten
        got_data.delete(); got_cyc.delete(); exp_data.delete(); exp_cyc_q.delete();
        for (int n = 0; n < 8; n++) begin
            repeat ($urandom_range(int'(baud) + 1, 3 * (int'(baud) + 1))) tick();
            b = $urandom_range(3, 40);
            baud = 16'(b);
            d = 8'($urandom_range(0, 255));
            send_frame(d, 1'b1);
            exp_data.push_back(d);
            exp_cyc_q.push_back(exp_rdy_cyc(last_e0, b));
        end
        repeat (10) tick();
        check("rand_count", got_data.size(), exp_data.size());
        nexp = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
        for (int i = 0; i < nexp; i++) begin
            check($sformatf("rand_data%0d", i), got_data[i], exp_data[i]);
            check($sformatf("rand_time%0d", i), got_cyc[i], exp_cyc_q[i]);
        end
        ack();

        // Minimum divisor; clr_rdy on the very cycle rdy sets
        repeat (10) tick();
        baud = 16'd3;
        got_data.delete(); got_cyc.delete();
        send_frame(8'h81, 1'b1);
        clr_rdy = 1'b1;
        tick();
        clr_rdy = 1'b0;
        check("b3_set_wins", rdy, 1);
        check("b3_data", rx_data, 8'h81);
        repeat (3) tick();
        check("b3_rdy_stays", rdy, 1);
        ack();
        check("b3_ack", rdy, 0);

        // Reset during data bit 4 of 0x55
        repeat (10) tick();
        baud = 16'd100;
        got_data.delete(); got_cyc.delete();
        begin
            logic [9:0] f;
            f = {1'b1, 8'h55, 1'b0};
            for (int i = 0; i < 6; i++) begin
                RX = f[i];
                repeat ((i < 5) ? 101 : 50) tick();
            end
        end
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_mid_rdy", rdy, 0);
        check("rst_mid_data", rx_data, 8'h00);
        RX = 1'b1;
        rst_n = 1'b1;
        repeat (700) tick();
        check("rst_no_pulse", got_data.size(), 0);
        send_frame(8'h12, 1'b1);
        e0 = last_e0;
        repeat (10) tick();
        check("rst_next_count", got_data.size(), 1);
        if (got_data.size() > 0) begin
            check("rst_next_data", got_data[0], 8'h12);
            check("rst_next_time", got_cyc[0], exp_rdy_cyc(e0, 100));
        end
        ack();

        // Stop bit low
        repeat (10) tick();
        baud = 16'd33;
        send_frame(8'h3C, 1'b0);
        repeat (10) tick();
        check("badstop_rdy", rdy, 1);
        check("badstop_data", rx_data, 8'h3C);
`ifdef UART_RX_FRM_CHK_EN
        check("badstop_frm", frm_err, 1);
`endif
        ack();
        check("badstop_ack_rdy", rdy, 0);
`ifdef UART_RX_FRM_CHK_EN
        check("badstop_ack_frm", frm_err, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
